// File: rtl/txn_sched_pkg.sv
// Shared types for the transaction scheduler: FSM state, request and response records.
package txn_sched_pkg;

  localparam int SCHED_AW    = 16;
  localparam int SCHED_DW    = 16;
  localparam int SCHED_DLY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [SCHED_AW-1:0]    addr;
    logic [SCHED_DW-1:0]    data;
    logic [SCHED_DLY_W-1:0] delay;
  } wr_req_t;

  typedef struct packed {
    logic [SCHED_AW-1:0]    addr;
    logic [SCHED_DW-1:0]    data;
    logic [SCHED_DLY_W-1:0] delay;
  } rd_req_t;

  typedef struct packed {
    logic                we;
    logic [SCHED_AW-1:0] addr;
    logic [SCHED_DW-1:0] data;
    logic                err;
  } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = write, bit 1 = read.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_rd_q, last_rd_d;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last_rd_q)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
    last_rd_d = update ? grant[1] : last_rd_q;
  end

  // Reset to "read served last" so write wins the first contested grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_rd_q <= 1'b1;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: rtl/txn_rw_scheduler.sv
// Arbitrates write/read requests, waits each one's idle delay, then runs one bus access with timeout.
module txn_rw_scheduler
  import txn_sched_pkg::*;
#(
  parameter int AW     = SCHED_AW,
  parameter int DW     = SCHED_DW,
  parameter int DLY_W  = SCHED_DLY_W,
  parameter int TO_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [DLY_W-1:0] wr_delay,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  input  logic [DLY_W-1:0] rd_delay,
  output logic             bus_req,
  output logic             bus_we,
  output logic [AW-1:0]    bus_addr,
  output logic [DW-1:0]    bus_wdata,
  input  logic             bus_ack,
  input  logic [DW-1:0]    bus_rdata,
  output logic             rsp_valid,
  output logic             rsp_we,
  output logic [AW-1:0]    rsp_addr,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_err
);

  localparam int TO_W = $clog2(TO_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_e          state_q, state_d;
  wr_req_t         req_q, req_d;
  rd_req_t         rd_req;
  logic            we_q, we_d;
  logic [TO_W-1:0] to_q, to_d;
  rsp_t            rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      grant;
  logic [1:0]      ready;
  logic            accept;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({rd_valid, wr_valid}),
    .update  (accept),
    .grant   (grant)
  );

  assign ready    = grant & {2{reset_n && (state_q == ST_IDLE)}};
  assign accept   = |(ready & {rd_valid, wr_valid});
  assign wr_ready = ready[0];
  assign rd_ready = ready[1];

  // The latched delay field doubles as the DELAY countdown.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    to_d        = to_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    rd_req      = '{addr: rd_addr, data: '0, delay: rd_delay};
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ready[0]) begin
            we_d  = 1'b1;
            req_d = '{addr: wr_addr, data: wr_data, delay: wr_delay};
          end else begin
            we_d  = 1'b0;
            req_d = wr_req_t'(rd_req);
          end
          to_d    = '0;
          state_d = (req_d.delay == '0) ? ST_ACCESS : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (req_q.delay <= DLY_W'(1)) begin
          state_d = ST_ACCESS;
          to_d    = '0;
        end else begin
          req_d.delay = req_q.delay - DLY_W'(1);
        end
      end
      ST_ACCESS: begin
        if (bus_ack) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_d       = '{we: we_q, addr: req_q.addr, data: (we_q ? '0 : bus_rdata), err: 1'b0};
        end else if (to_q == TO_LAST) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_d       = '{we: we_q, addr: req_q.addr, data: '0, err: 1'b1};
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      we_q        <= 1'b0;
      to_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      to_q        <= to_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus_req   = (state_q == ST_ACCESS);
  assign bus_we    = we_q;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.data;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_q.we;
  assign rsp_addr  = rsp_q.addr;
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_txn_rw_scheduler.sv
// Directed bench for txn_rw_scheduler: vector table plus hand-written arbitration, timeout and reset sequences.
module tb_txn_rw_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_addr, wr_data;
  logic [7:0]  wr_delay;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_addr;
  logic [7:0]  rd_delay;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        rsp_valid, rsp_we;
  logic [15:0] rsp_addr, rsp_data;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  txn_rw_scheduler #(.AW(16), .DW(16), .DLY_W(8), .TO_CYC(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_delay  (wr_delay),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_delay  (rd_delay),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .rsp_valid (rsp_valid),
    .rsp_we    (rsp_we),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        wv, rv;
    logic [15:0] waddr, wdata, raddr;
    logic [7:0]  wdly, rdly;
    logic        spur;
    int          ack_wait;
    logic [15:0] rdata;
    logic        exp_we;
    int          exp_dly;
    logic [15:0] exp_addr, exp_wdata, exp_rsp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    bus_ack  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    wr_valid = v.wv; wr_addr = v.waddr; wr_data = v.wdata; wr_delay = v.wdly;
    rd_valid = v.rv; rd_addr = v.raddr; rd_delay = v.rdly;
    #1;
    chk($sformatf("v%0d_wr_ready", idx), wr_ready, v.exp_we);
    chk($sformatf("v%0d_rd_ready", idx), rd_ready, !v.exp_we);
    @(negedge clk);
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    n = 1;
    if (v.spur) bus_ack = 1'b1;
    while (!bus_req && n < 400) begin
      @(negedge clk);
      n++;
      if (bus_ack) begin
        bus_ack = 1'b0;
        chk($sformatf("v%0d_spur_rsp", idx), rsp_valid, 1'b0);
      end
    end
    chk($sformatf("v%0d_issue_latency", idx), n, v.exp_dly + 1);
    chk($sformatf("v%0d_bus_we", idx), bus_we, v.exp_we);
    chk($sformatf("v%0d_bus_addr", idx), bus_addr, v.exp_addr);
    chk($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_wdata);
    repeat (v.ack_wait) @(negedge clk);
    chk($sformatf("v%0d_req_held", idx), bus_req, 1'b1);
    bus_ack = 1'b1;
    bus_rdata = v.rdata;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = 16'hDEAD;
    chk($sformatf("v%0d_req_drop", idx), bus_req, 1'b0);
    chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1'b1);
    chk($sformatf("v%0d_rsp_we", idx), rsp_we, v.exp_we);
    chk($sformatf("v%0d_rsp_addr", idx), rsp_addr, v.exp_addr);
    chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_rsp);
    chk($sformatf("v%0d_rsp_err", idx), rsp_err, 1'b0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_pulse_end", idx), rsp_valid, 1'b0);
    chk($sformatf("v%0d_rsp_addr_hold", idx), rsp_addr, v.exp_addr);
    $display("vec %0d: we=%0d addr=%h latency=%0d rsp_data=%h", idx, v.exp_we, v.exp_addr, n, rsp_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    logic gq_we[$];
    int   gq_cyc[$];

    //                  wv    rv    waddr     wdata     raddr     wdly   rdly     spur  aw rdata     we    dly addr      wdata     rsp
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 8'd0,  8'd0,   1'b0, 1, 16'h0000, 1'b1, 0,   16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0020, 8'd0,  8'd3,   1'b0, 1, 16'h1234, 1'b0, 3,   16'h0020, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 16'h1111, 16'hA5A5, 16'h2222, 8'd1,  8'd2,   1'b0, 0, 16'hFFFF, 1'b1, 1,   16'h1111, 16'hA5A5, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h3333, 16'h5A5A, 16'h4444, 8'd0,  8'd0,   1'b0, 3, 16'hC3C3, 1'b0, 0,   16'h4444, 16'h0000, 16'hC3C3};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 8'd4,  8'd0,   1'b1, 0, 16'h7777, 1'b1, 4,   16'hFFFF, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h00FF, 8'd0,  8'd255, 1'b0, 2, 16'h0001, 1'b0, 255, 16'h00FF, 16'h0000, 16'h0001};

    wr_addr = '0; wr_data = '0; wr_delay = '0;
    rd_addr = '0; rd_delay = '0; bus_rdata = '0;
    reset_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_fields", {bus_we, bus_addr, bus_wdata}, 33'h0);
    chk("rst_rsp_fields", {rsp_valid, rsp_we, rsp_err, rsp_addr, rsp_data}, 35'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_first_grant_wr", wr_ready, 1'b1);
    chk("rst_first_grant_rd", rd_ready, 1'b0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    $display("reset: outputs idle, write granted first");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Spurious ack while idle must not produce a response.
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("idle_spur_rsp", rsp_valid, 1'b0);
    chk("idle_spur_req", bus_req, 1'b0);
    $display("idle spurious ack: rsp_valid=%0d", rsp_valid);

    // Both requesters always valid, zero delay, device acks on the 2nd access cycle.
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_delay = 8'd0; wr_addr = 16'h00A0; wr_data = 16'h1357;
    rd_valid = 1'b1; rd_delay = 8'd0; rd_addr = 16'h00B0; bus_rdata = 16'h5555;
    #1;
    acc = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (bus_req) acc++; else acc = 0;
      bus_ack = bus_req && (acc == 2);
      if (wr_ready) begin gq_we.push_back(1'b1); gq_cyc.push_back(cyc); end
      if (rd_ready) begin gq_we.push_back(1'b0); gq_cyc.push_back(cyc); end
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (bus_req) acc++; else acc = 0;
      bus_ack = bus_req && (acc == 2);
      @(negedge clk);
    end
    bus_ack = 1'b0;
    chk("alt_grant_count", gq_we.size(), 5);
    for (int i = 0; i < gq_we.size(); i++) begin
      chk($sformatf("alt_grant%0d_side", i), gq_we[i], (i % 2 == 0));
      if (i > 0) chk($sformatf("alt_grant%0d_gap", i), gq_cyc[i] - gq_cyc[i-1], 3);
      $display("alt grant %0d: %s at cycle %0d", i, gq_we[i] ? "W" : "R", gq_cyc[i]);
    end

    // Read with no ack: 64 cycles of bus_req, then error response.
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 16'h0BAD; rd_delay = 8'd0; bus_rdata = 16'h9999;
    #1;
    chk("to_rd_ready", rd_ready, 1'b1);
    @(negedge clk);
    rd_valid = 1'b0;
    n = 0;
    while (bus_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 64);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_data", rsp_data, 16'h0000);
    chk("to_rsp_addr", rsp_addr, 16'h0BAD);
    chk("to_rsp_we", rsp_we, 1'b0);
    $display("timeout: bus_req cycles=%0d rsp_err=%0d", n, rsp_err);
    run_vec(10, vecs[0]);

    // Reset asserted for one cycle mid-access.
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 16'h00AA; rd_delay = 8'd0;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("rsta_in_access", bus_req, 1'b1);
    reset_n = 1'b0;
    bus_ack = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    chk("rsta_ready_forced", {wr_ready, rd_ready}, 2'b00);
    @(negedge clk);
    chk("rsta_bus_req", bus_req, 1'b0);
    chk("rsta_rsp_valid", rsp_valid, 1'b0);
    chk("rsta_bus_fields", {bus_we, bus_addr, bus_wdata}, 33'h0);
    chk("rsta_rsp_fields", {rsp_we, rsp_err, rsp_addr, rsp_data}, 34'h0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rsta_no_rsp", rsp_valid, 1'b0);
    $display("mid-access reset: bus_req=%0d rsp_valid=%0d", bus_req, rsp_valid);
    run_vec(20, vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
